// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters over valid/ready handshakes.
// Optional illegal-opcode check enabled by defining ALU_ARB_SELCHK_EN.
module alu_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ALU_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [DATA_W-1:0] i_req0_op1,
  input  logic [DATA_W-1:0] i_req0_op2,
  input  logic [2:0]        i_req0_sel,
  input  logic [DATA_W-1:0] i_req1_op1,
  input  logic [DATA_W-1:0] i_req1_op2,
  input  logic [2:0]        i_req1_sel,
  output logic [1:0]        o_rsp_valid,
  input  logic [1:0]        i_rsp_ready,
  output logic [2*DATA_W-1:0] o_rsp_result,
  output logic              o_rsp_zero,
  output logic              o_rsp_err,
  output logic [DATA_W-1:0] o_alu_op1,
  output logic [DATA_W-1:0] o_alu_op2,
  output logic [2:0]        o_alu_sel,
  input  logic [2*DATA_W-1:0] i_alu_result,
  input  logic              i_alu_zero,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [2:0] SEL_NOP  = 3'b100;
  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
  logic [2:0]          alu_sel_q, alu_sel_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;

  logic                pick_s;
  logic [DATA_W-1:0]   pick_op1_s;
  logic [DATA_W-1:0]   pick_op2_s;
  logic [2:0]          pick_sel_s;
  logic                pick_illegal_s;
  logic [1:0]          req_ready_s;

`ifdef ALU_ARB_SELCHK_EN
  function automatic logic sel_illegal(input logic [2:0] sel);
    return (sel > SEL_NOP);
  endfunction
  assign pick_illegal_s = sel_illegal(pick_sel_s);
`else
  assign pick_illegal_s = 1'b0;
`endif

  // Round-robin pick: on contention the requester that was not served last wins.
  always_comb begin
    pick_s = 1'b0;
    if (i_req_valid == 2'b11) begin
      pick_s = ~last_q;
    end else begin
      pick_s = i_req_valid[1];
    end
    pick_op1_s = pick_s ? i_req1_op1 : i_req0_op1;
    pick_op2_s = pick_s ? i_req1_op2 : i_req0_op2;
    pick_sel_s = pick_s ? i_req1_sel : i_req0_sel;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_sel_d   = alu_sel_q;
    res_d       = res_q;
    zero_d      = zero_q;
    err_d       = err_q;
    req_ready_s = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid != 2'b00) begin
          req_ready_s = pick_s ? 2'b10 : 2'b01;
          gnt_d       = pick_s;
          cnt_d       = CNT_INIT;
          err_d       = pick_illegal_s;
          if (pick_illegal_s) begin
            // Illegal opcode: ALU stays idle and a canned error response is produced.
            res_d   = '0;
            zero_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            alu_op1_d = pick_op1_s;
            alu_op2_d = pick_op2_s;
            alu_sel_d = pick_sel_s;
            state_d   = S_EXEC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d   = i_alu_result;
          zero_d  = i_alu_zero;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready[gnt_q]) begin
          alu_op1_d = '0;
          alu_op2_d = '0;
          alu_sel_d = SEL_NOP;
          last_d    = gnt_q;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        alu_op1_d = '0;
        alu_op2_d = '0;
        alu_sel_d = SEL_NOP;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= 4'd0;
      alu_op1_q <= '0;
      alu_op2_q <= '0;
      alu_sel_q <= SEL_NOP;
      res_q     <= '0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      alu_op1_q <= alu_op1_d;
      alu_op2_q <= alu_op2_d;
      alu_sel_q <= alu_sel_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
    end
  end

  assign o_req_ready  = req_ready_s;
  assign o_rsp_valid  = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_result = res_q;
  assign o_rsp_zero   = zero_q;
  assign o_rsp_err    = err_q;
  assign o_alu_op1    = alu_op1_q;
  assign o_alu_op2    = alu_op2_q;
  assign o_alu_sel    = alu_sel_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// against a transaction-level model (accept time, grant order, expected response).
module tb_alu_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] r0_op1, r0_op2, r1_op1, r1_op2;
  logic [2:0]  r0_sel, r1_sel;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [15:0] alu_op1, alu_op2;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(16), .ALU_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req0_op1(r0_op1), .i_req0_op2(r0_op2), .i_req0_sel(r0_sel),
    .i_req1_op1(r1_op1), .i_req1_op2(r1_op2), .i_req1_sel(r1_sel),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero), .o_rsp_err(rsp_err),
    .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .o_alu_sel(alu_sel),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero), .o_busy(busy)
  );

  // Behavioural ALU attached to the DUT
  function automatic logic [31:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] s);
    case (s)
      3'b000:  return {16'd0, a} + {16'd0, b};
      3'b001:  return {16'd0, a} - {16'd0, b};
      3'b010:  return {16'd0, a & b};
      3'b011:  return {16'd0, a | b};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op1, alu_op2, alu_sel);
  assign alu_zero   = (alu_result == 32'd0);

  function automatic bit illegal(input logic [2:0] s);
`ifdef ALU_ARB_SELCHK_EN
    return (s > 3'b100);
`else
    return 1'b0;
`endif
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pending requests per requester and the transaction model
  bit          pv [2];
  logic [15:0] pop1 [2];
  logic [15:0] pop2 [2];
  logic [2:0]  psel [2];
  bit          m_busy, m_g, m_last;
  int          m_acc, cyc, n_done;
  int          grants [$];
  logic [15:0] m_op1, m_op2;
  logic [2:0]  m_sel;

  task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] s);
    pv[r] = 1'b1; pop1[r] = a; pop2[r] = b; psel[r] = s;
  endtask

  task automatic cycle(input logic [1:0] rdy);
    logic [1:0]  exp_ready, exp_rv;
    logic [15:0] e_op1, e_op2;
    logic [2:0]  e_sel;
    logic [31:0] e_res;
    bit          ill;
    req_valid = {pv[1], pv[0]};
    r0_op1 = pop1[0]; r0_op2 = pop2[0]; r0_sel = psel[0];
    r1_op1 = pop1[1]; r1_op2 = pop2[1]; r1_sel = psel[1];
    rsp_ready = rdy;
    #1;
    ill = illegal(m_sel);
    if (!m_busy) begin
      if (pv[0] && pv[1]) exp_ready = m_last ? 2'b01 : 2'b10;
      else                exp_ready = {pv[1], pv[0]};
      exp_rv = 2'b00;
      e_op1 = 16'd0; e_op2 = 16'd0; e_sel = 3'b100;
    end else begin
      exp_ready = 2'b00;
      exp_rv = (cyc >= m_acc + (ill ? 0 : LAT)) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      e_op1 = ill ? 16'd0 : m_op1;
      e_op2 = ill ? 16'd0 : m_op2;
      e_sel = ill ? 3'b100 : m_sel;
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(m_busy));
    check("alu_op1", 32'(alu_op1), 32'(e_op1));
    check("alu_op2", 32'(alu_op2), 32'(e_op2));
    check("alu_sel", 32'(alu_sel), 32'(e_sel));
    if (exp_rv != 2'b00) begin
      e_res = ill ? 32'd0 : alu_fn(m_op1, m_op2, m_sel);
      check("rsp_result", rsp_result, e_res);
      check("rsp_zero", 32'(rsp_zero), 32'(e_res == 32'd0));
      check("rsp_err", 32'(rsp_err), 32'(ill));
    end
    if (!m_busy && exp_ready != 2'b00) begin
      m_g = exp_ready[1];
      m_busy = 1'b1;
      m_acc = cyc + 1;
      m_op1 = pop1[m_g]; m_op2 = pop2[m_g]; m_sel = psel[m_g];
      pv[m_g] = 1'b0;
      grants.push_back(int'(m_g));
    end else if (m_busy && exp_rv != 2'b00 && rdy[m_g]) begin
      m_busy = 1'b0;
      m_last = m_g;
      n_done++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_zero", 32'(rsp_zero), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_alu_op1", 32'(alu_op1), 32'd0);
    check("rst_alu_op2", 32'(alu_op2), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd4);
  endtask

  // Asynchronous reset pulse taken mid-cycle; any model transaction is dropped
  task automatic do_reset();
    pv[0] = 1'b0; pv[1] = 1'b0;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    m_busy = 1'b0; m_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    r0_op1 = 16'd0; r0_op2 = 16'd0; r0_sel = 3'd0;
    r1_op1 = 16'd0; r1_op2 = 16'd0; r1_sel = 3'd0;
    for (int r = 0; r < 2; r++) begin
      pv[r] = 1'b0; pop1[r] = 16'd0; pop2[r] = 16'd0; psel[r] = 3'd0;
    end
    m_busy = 1'b0; m_g = 1'b0; m_last = 1'b1; m_acc = 0; cyc = 0; n_done = 0;
    m_op1 = 16'd0; m_op2 = 16'd0; m_sel = 3'd0;

    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD from requester 0
    set_req(0, 16'd10, 16'd22, 3'b000);
    repeat (LAT + 3) cycle(2'b01);
    check("add_result", rsp_result, 32'd32);

    // Simultaneous contest straight after reset: requester 0 first
    do_reset();
    grants.delete();
    set_req(0, 16'd20, 16'd20, 3'b001);
    set_req(1, 16'd100, 16'd125, 3'b010);
    repeat (2 * (LAT + 2) + 2) cycle(2'b11);
    check("contest_n", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      check("contest_g0", 32'(grants[0]), 32'd0);
      check("contest_g1", 32'(grants[1]), 32'd1);
    end
    check("contest_last", rsp_result, 32'd100);

    // Backpressure on requester 0 while requester 1 waits
    set_req(0, 16'd1, 16'd2, 3'b011);
    set_req(1, 16'd5, 16'd6, 3'b000);
    repeat (LAT + 6) cycle(2'b00);
    check("bp_pending1", 32'(pv[1]), 32'd1);
    repeat (2 * (LAT + 2) + 2) cycle(2'b11);

    // Continuous contention: grants alternate
    grants.delete();
    for (int i = 0; i < 4 * (LAT + 2) + 1; i++) begin
      if (!pv[0]) set_req(0, 16'd90, 16'd30, 3'b011);
      if (!pv[1]) set_req(1, 16'd34, 16'd45, 3'b100);
      cycle(2'b11);
    end
    check("alt_n", 32'(grants.size() >= 4), 32'd1);
    for (int i = 1; i < grants.size(); i++)
      check("alt_order", 32'(grants[i]), 32'(grants[i-1] ^ 1));
    pv[0] = 1'b0; pv[1] = 1'b0;
    repeat (LAT + 3) cycle(2'b11);

    // Reset during EXEC drops the response; a fresh ADD then completes
    set_req(0, 16'd10, 16'd22, 3'b000);
    cycle(2'b01);
    cycle(2'b01);
    do_reset();
    repeat (LAT + 1) cycle(2'b11);
    set_req(0, 16'd10, 16'd22, 3'b000);
    n_done = 0;
    repeat (LAT + 3) cycle(2'b01);
    check("post_rst_done", 32'(n_done), 32'd1);
    check("post_rst_result", rsp_result, 32'd32);

    // Selector 3'b110: illegal with the check enabled, passed through otherwise
    set_req(1, 16'd7, 16'd9, 3'b110);
    repeat (LAT + 3) cycle(2'b10);

    // Random traffic with random response backpressure
    for (int i = 0; i < 800; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pv[r] && $urandom_range(0, 2) != 0)
          set_req(r, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
      cycle(2'($urandom));
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    repeat (LAT + 4) cycle(2'b11);
    check("drain_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
